// File: rtl/matmul_param_top.sv
// matmul_param_top: run-time sized square matrix multiply engine, Z = X * Y.
// The host fills the X and Y BRAMs, pulses start with a dimension n, waits for done
// and then reads Z. X, Y and Z each sit in a simple-dual-port BRAM with a 1-cycle read.
// Optional feature: define MATMUL_CYCLE_COUNT_EN to add the cycle_count output.
// That output is a saturating count of the busy cycles in the last accepted run.
module matmul_param_top #(
   parameter int DATA_WIDTH = 32,
   parameter int MAX_DIM    = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int DIM_WIDTH  = 6
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DIM_WIDTH-1:0]  dim,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   input  logic [DATA_WIDTH-1:0] x_din,
   input  logic [ADDR_WIDTH-1:0] x_wr_addr,
   input  logic                  x_wr_en,
   input  logic [DATA_WIDTH-1:0] y_din,
   input  logic [ADDR_WIDTH-1:0] y_wr_addr,
   input  logic                  y_wr_en,
   input  logic [ADDR_WIDTH-1:0] z_rd_addr,
   output logic [DATA_WIDTH-1:0] z_dout
`ifdef MATMUL_CYCLE_COUNT_EN
   ,
   output logic [31:0]           cycle_count
`endif
);

   localparam int ACC_W  = 2*DATA_WIDTH + DIM_WIDTH;
   localparam int PROD_W = 2*DATA_WIDTH;
   localparam int DEPTH  = 1 << ADDR_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_MAC,
      S_DRAIN,
      S_WRITE,
      S_FIN
   } state_t;

   // Row-major element address r*n + c. It always fits because r,c < n and n*n <= DEPTH.
   function automatic logic [ADDR_WIDTH-1:0] calc_addr(
      input logic [DIM_WIDTH-1:0] row,
      input logic [DIM_WIDTH-1:0] col,
      input logic [DIM_WIDTH-1:0] nn
   );
      return ADDR_WIDTH'(row) * ADDR_WIDTH'(nn) + ADDR_WIDTH'(col);
   endfunction

   // Sign-extend a full-width product into the accumulator width.
   function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
      return ACC_W'(p);
   endfunction

   // Z keeps only the low DATA_WIDTH bits; overflow wraps, it never saturates.
   function automatic logic [DATA_WIDTH-1:0] wrap_acc(input logic signed [ACC_W-1:0] a);
      return DATA_WIDTH'(a);
   endfunction

   // Storage
   logic [DATA_WIDTH-1:0] x_mem [0:DEPTH-1];
   logic [DATA_WIDTH-1:0] y_mem [0:DEPTH-1];
   logic [DATA_WIDTH-1:0] z_mem [0:DEPTH-1];

   // Control state
   state_t               state, state_nxt;
   logic [DIM_WIDTH-1:0] n_q;
   logic [DIM_WIDTH-1:0] i_q;
   logic [DIM_WIDTH-1:0] j_q;
   logic [DIM_WIDTH-1:0] k_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 err_q;

   // Decodes
   logic                 dim_bad;
   logic                 last_k;
   logic                 last_j;
   logic                 last_i;
   logic                 issue;
   logic                 z_we;

   // Datapath
   logic [ADDR_WIDTH-1:0]     x_rd_addr_p0;
   logic [ADDR_WIDTH-1:0]     y_rd_addr_p0;
   logic [ADDR_WIDTH-1:0]     z_wr_addr;
   logic signed [DATA_WIDTH-1:0] x_rd_p1;
   logic signed [DATA_WIDTH-1:0] y_rd_p1;
   logic                      vld_p1;
   logic signed [PROD_W-1:0]  prod_p1;
   logic signed [ACC_W-1:0]   acc_p2;

   assign dim_bad = (n_q == '0) || (n_q > DIM_WIDTH'(MAX_DIM));
   assign last_k  = (k_q == n_q - DIM_WIDTH'(1));
   assign last_j  = (j_q == n_q - DIM_WIDTH'(1));
   assign last_i  = (i_q == n_q - DIM_WIDTH'(1));

   assign x_rd_addr_p0 = calc_addr(i_q, k_q, n_q);
   assign y_rd_addr_p0 = calc_addr(k_q, j_q, n_q);
   assign z_wr_addr    = calc_addr(i_q, j_q, n_q);

   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode plus the per-state issue and write strobes
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      z_we      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_CHECK;
            end
         end
         S_CHECK: begin
            state_nxt = dim_bad ? S_FIN : S_MAC;
         end
         S_MAC: begin
            issue = 1'b1;
            if (last_k) begin
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            state_nxt = S_WRITE;
         end
         S_WRITE: begin
            z_we      = 1'b1;
            state_nxt = (last_i && last_j) ? S_FIN : S_MAC;
         end
         S_FIN: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Status flags, the latched dimension and the i/j/k loop counters
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         n_q    <= '0;
         i_q    <= '0;
         j_q    <= '0;
         k_q    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  n_q    <= dim;
                  done_q <= 1'b0;
                  err_q  <= 1'b0;
               end
            end
            S_CHECK: begin
               i_q <= '0;
               j_q <= '0;
               k_q <= '0;
               if (dim_bad) begin
                  err_q <= 1'b1;
               end else begin
                  busy_q <= 1'b1;
               end
            end
            S_MAC: begin
               k_q <= last_k ? '0 : k_q + DIM_WIDTH'(1);
            end
            S_WRITE: begin
               k_q <= '0;
               if (last_j) begin
                  j_q <= '0;
                  i_q <= i_q + DIM_WIDTH'(1);
               end else begin
                  j_q <= j_q + DIM_WIDTH'(1);
               end
            end
            S_FIN: begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // Host writes into X and Y; they are dropped while the engine is busy
   always_ff @(posedge clock) begin
      if (x_wr_en && !busy_q) begin
         x_mem[x_wr_addr] <= x_din;
      end
      if (y_wr_en && !busy_q) begin
         y_mem[y_wr_addr] <= y_din;
      end
   end

   // ---- stage p0 -> p1: BRAM read of X[i][k] and Y[k][j] ----
   always_ff @(posedge clock) begin
      x_rd_p1 <= x_mem[x_rd_addr_p0];
      y_rd_p1 <= y_mem[y_rd_addr_p0];
   end

   // Marks which cycles carry a real X/Y pair back from the BRAMs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= issue;
      end
   end

   assign prod_p1 = PROD_W'(x_rd_p1) * PROD_W'(y_rd_p1);

   // ---- stage p1 -> p2: accumulate; cleared at the start of a run and after each Z write ----
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         acc_p2 <= '0;
      end else if ((state == S_CHECK) || z_we) begin
         acc_p2 <= '0;
      end else if (vld_p1) begin
         acc_p2 <= acc_p2 + sext_prod(prod_p1);
      end
   end

   // Engine writes Z; a host read of the same address in that cycle sees the old data
   always_ff @(posedge clock) begin
      if (z_we) begin
         z_mem[z_wr_addr] <= wrap_acc(acc_p2);
      end
   end

   // Host Z read port, always live
   always_ff @(posedge clock) begin
      z_dout <= z_mem[z_rd_addr];
   end

`ifdef MATMUL_CYCLE_COUNT_EN
   // Saturating count of busy cycles, restarted on every accepted start
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cycle_count <= '0;
      end else if ((state == S_IDLE) && start) begin
         cycle_count <= '0;
      end else if (busy_q && (cycle_count != 32'hFFFF_FFFF)) begin
         cycle_count <= cycle_count + 32'd1;
      end
   end
`endif

endmodule
